rvb_seg_sequencer: RTL and testbench

//  Output stage between the RISC-V core's debug-port byte writes and the 7-segment pins.

---
 rtl/rvb_seg_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_rvb_seg_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rvb_seg_sequencer.sv
// rvb_seg_sequencer
// Output stage that takes bytes written by the core's debug port, queues them
// in a small FIFO and shows each byte on one 7-segment display as two hex
// digits: high digit, blank gap, low digit, blank gap.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   CNT_W  dwell/gap counter width
//   DWELL  cycles each digit is shown (>= 1, < 2**CNT_W)
//   GAP    blank cycles after each digit (0 removes the gap phases)
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   wr_en     write strobe from the core
//   wr_data   byte to display
//   wr_ready  FIFO not full
//   busy      sequencer not idle or FIFO holding bytes
//   overflow  sticky flag: a write was dropped because the FIFO was full
//   segments  [0]=a .. [6]=g, registered
//
// Configuration macro: SEG_ACTIVE_LOW_EN inverts segments for common-anode
// displays (blank/reset value becomes 7'h7F).
module rvb_seg_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 24,
    parameter int DWELL = 1000000,
    parameter int GAP   = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       busy,
    output logic       overflow,
    output logic [6:0] segments
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP == 0) ? {CNT_W{1'b0}} : CNT_W'(GAP - 1);
    localparam logic [AW:0]      FULL_COUNT = (AW + 1)'(DEPTH);

`ifdef SEG_ACTIVE_LOW_EN
    localparam logic [6:0] SEG_POL = 7'h7F;
`else
    localparam logic [6:0] SEG_POL = 7'h00;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHOW_HI = 3'd1,
        ST_GAP_HI  = 3'd2,
        ST_SHOW_LO = 3'd3,
        ST_GAP_LO  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cur_q, cur_d;
    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [6:0]       segments_q, segments_d;
    logic             overflow_q, overflow_d;
    logic             push_s;
    logic             pop_s;
    logic             byte_done_s;
    logic             load_s;

    // Active-high hex font, a..g in bits 0..6.
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_font = 7'h3F;
            4'h1:    hex_font = 7'h06;
            4'h2:    hex_font = 7'h5B;
            4'h3:    hex_font = 7'h4F;
            4'h4:    hex_font = 7'h66;
            4'h5:    hex_font = 7'h6D;
            4'h6:    hex_font = 7'h7D;
            4'h7:    hex_font = 7'h07;
            4'h8:    hex_font = 7'h7F;
            4'h9:    hex_font = 7'h6F;
            4'hA:    hex_font = 7'h77;
            4'hB:    hex_font = 7'h7C;
            4'hC:    hex_font = 7'h39;
            4'hD:    hex_font = 7'h5E;
            4'hE:    hex_font = 7'h79;
            4'hF:    hex_font = 7'h71;
            default: hex_font = 7'h00;
        endcase
    endfunction

    // Full flag comes straight from the registered count; a full FIFO drops the write
    // even when a pop happens on the same edge.
    assign wr_ready = (count_q != FULL_COUNT);
    assign push_s   = wr_en & wr_ready;
    assign busy     = (state_q != ST_IDLE) || (count_q != {(AW + 1){1'b0}});
    assign overflow = overflow_q;
    assign segments = segments_q;

    // Sequencer next state: phase timing, byte fetch and registered segment value.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_d       = cur_q;
        pop_s       = 1'b0;
        byte_done_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_SHOW_HI: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (GAP == 0) begin
                    state_d = ST_SHOW_LO;
                    cnt_d   = DWELL_LOAD;
                end else begin
                    state_d = ST_GAP_HI;
                    cnt_d   = GAP_LOAD;
                end
            end
            ST_GAP_HI: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_SHOW_LO;
                    cnt_d   = DWELL_LOAD;
                end
            end
            ST_SHOW_LO: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (GAP == 0) begin
                    byte_done_s = 1'b1;
                end else begin
                    state_d = ST_GAP_LO;
                    cnt_d   = GAP_LOAD;
                end
            end
            ST_GAP_LO: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    byte_done_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        // Idle or end of a byte: fetch the next byte directly, so consecutive bytes
        // run back to back with no idle cycle.
        load_s = (state_q == ST_IDLE) || byte_done_s;
        if (load_s && (count_q != {(AW + 1){1'b0}})) begin
            pop_s   = 1'b1;
            cur_d   = mem_q[rd_ptr_q];
            state_d = ST_SHOW_HI;
            cnt_d   = DWELL_LOAD;
        end else if (load_s) begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            pop_s = 1'b0;
        end

        // Segment value follows the next state so the first digit appears one edge after the pop.
        case (state_d)
            ST_SHOW_HI: segments_d = hex_font(cur_d[7:4]) ^ SEG_POL;
            ST_SHOW_LO: segments_d = hex_font(cur_d[3:0]) ^ SEG_POL;
            default:    segments_d = SEG_POL;
        endcase
    end

    // FIFO pointer/count and sticky overflow next state.
    always_comb begin
        wr_ptr_d   = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d   = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        overflow_d = overflow_q | (wr_en & ~wr_ready);
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            cur_q      <= 8'h00;
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {(AW + 1){1'b0}};
            segments_q <= SEG_POL;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            segments_q <= segments_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents are cleared so reset leaves no stale bytes visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_rvb_seg_sequencer.sv
module tb_rvb_seg_sequencer;

    localparam int D     = 4;
    localparam int DEPTH = 4;
    localparam int MAXN  = 256;

`ifdef SEG_ACTIVE_LOW_EN
    localparam logic [6:0] POL = 7'h7F;
`else
    localparam logic [6:0] POL = 7'h00;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rdy2, busy2, ovf2;
    logic [6:0] seg2;
    logic       rdy0, busy0, ovf0;
    logic [6:0] seg0;

    int errors = 0;
    int checks = 0;

    bit         stim_en [MAXN];
    logic [7:0] stim_d  [MAXN];

    logic [6:0] font_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    rvb_seg_sequencer #(.DEPTH(DEPTH), .CNT_W(24), .DWELL(D), .GAP(2)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(rdy2), .busy(busy2), .overflow(ovf2), .segments(seg2)
    );

    rvb_seg_sequencer #(.DEPTH(DEPTH), .CNT_W(24), .DWELL(D), .GAP(0)) u_dut_g0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(rdy0), .busy(busy0), .overflow(ovf0), .segments(seg0)
    );

    task automatic apply_reset;
        @(negedge clk);
        #1 rst = 1'b1;
        wr_en = 1'b0;
        #2 rst = 1'b0;
    endtask

    task automatic clear_stim;
        for (int i = 0; i < MAXN; i++) begin
            stim_en[i] = 1'b0;
            stim_d[i]  = 8'h00;
        end
    endtask

    // Drives stim_* for n edges after a reset and checks the selected DUT
    // (g = its GAP) every cycle against a timeline model: each accepted byte
    // starts at max(accept+1, end of previous byte) and occupies 2*(D+g) cycles.
    task automatic run_scenario(input int g, input int n, input string name);
        int         e_q[$];
        int         s_q[$];
        logic [7:0] b_q[$];
        int         drop_at;
        int         free_at;
        int         len;
        int         occ;
        int         o;
        logic [6:0] exp_seg;
        logic       exp_busy, exp_rdy, exp_ovf;
        logic [6:0] obs_seg;
        logic       obs_busy, obs_rdy, obs_ovf;
        drop_at = -1;
        free_at = 0;
        len     = 2 * (D + g);
        for (int t = 0; t < n; t++) begin
            if (stim_en[t]) begin
                occ = 0;
                foreach (e_q[k]) if (e_q[k] <= t - 1 && s_q[k] > t - 1) occ++;
                if (occ < DEPTH) begin
                    e_q.push_back(t);
                    s_q.push_back((t + 1 > free_at) ? t + 1 : free_at);
                    b_q.push_back(stim_d[t]);
                    free_at = s_q[s_q.size() - 1] + len;
                end else if (drop_at < 0) begin
                    drop_at = t;
                end
            end
        end
        apply_reset();
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            wr_en   = stim_en[t];
            wr_data = stim_d[t];
            @(posedge clk);
            #1;
            exp_seg  = POL;
            exp_busy = 1'b0;
            occ      = 0;
            foreach (s_q[k]) begin
                if (t >= s_q[k] && t < s_q[k] + len) begin
                    o = t - s_q[k];
                    if (o < D)               exp_seg = font_tab[b_q[k][7:4]] ^ POL;
                    else if (o >= D + g && o < 2 * D + g)
                                             exp_seg = font_tab[b_q[k][3:0]] ^ POL;
                end
                if (t >= e_q[k] && t < s_q[k] + len) exp_busy = 1'b1;
                if (e_q[k] <= t && s_q[k] > t) occ++;
            end
            exp_rdy = (occ != DEPTH);
            exp_ovf = (drop_at >= 0) && (t >= drop_at);
            obs_seg  = (g == 0) ? seg0  : seg2;
            obs_busy = (g == 0) ? busy0 : busy2;
            obs_rdy  = (g == 0) ? rdy0  : rdy2;
            obs_ovf  = (g == 0) ? ovf0  : ovf2;
            checks++;
            if (obs_seg !== exp_seg) begin
                errors++;
                $display("FAIL %s segments t=%0d got %h expected %h", name, t, obs_seg, exp_seg);
            end
            checks++;
            if (obs_busy !== exp_busy) begin
                errors++;
                $display("FAIL %s busy t=%0d got %b expected %b", name, t, obs_busy, exp_busy);
            end
            checks++;
            if (obs_rdy !== exp_rdy) begin
                errors++;
                $display("FAIL %s wr_ready t=%0d got %b expected %b", name, t, obs_rdy, exp_rdy);
            end
            checks++;
            if (obs_ovf !== exp_ovf) begin
                errors++;
                $display("FAIL %s overflow t=%0d got %b expected %b", name, t, obs_ovf, exp_ovf);
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Overflow a busy DUT, then assert rst between edges and check outputs at once.
    task automatic test_reset;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (ovf2 !== 1'b1 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre overflow/busy got %b/%b expected 1/1", ovf2, busy2);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (seg2 !== POL || rdy2 !== 1'b1 || busy2 !== 1'b0 || ovf2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_async seg/rdy/busy/ovf got %h/%b/%b/%b expected %h/1/0/0",
                     seg2, rdy2, busy2, ovf2, POL);
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_single;
        clear_stim();
        stim_en[0] = 1'b1;
        stim_d[0]  = 8'h3A;
        run_scenario(2, 16, "single_3A");
    endtask

    task automatic test_back_to_back;
        clear_stim();
        stim_en[0] = 1'b1; stim_d[0] = 8'h12;
        stim_en[1] = 1'b1; stim_d[1] = 8'h34;
        run_scenario(2, 28, "b2b_12_34");
    endtask

    task automatic test_overflow;
        clear_stim();
        for (int i = 0; i < 6; i++) begin
            stim_en[i] = 1'b1;
            stim_d[i]  = 8'(i);
        end
        run_scenario(2, 66, "overflow");
    endtask

    task automatic test_random;
        clear_stim();
        for (int i = 0; i < 200; i++) begin
            stim_en[i] = ($urandom_range(0, 5) == 0);
            stim_d[i]  = 8'($urandom);
        end
        run_scenario(2, 220, "random_g2");
        clear_stim();
        for (int i = 0; i < 120; i++) begin
            stim_en[i] = ($urandom_range(0, 3) == 0);
            stim_d[i]  = 8'($urandom);
        end
        run_scenario(0, 140, "random_g0");
    endtask

    // rst during SHOW_LO of 0x3A with 0x55 queued: 0x55 must never appear.
    task automatic test_reset_mid;
        apply_reset();
        for (int t = 0; t < 9; t++) begin
            @(negedge clk);
            wr_en   = (t < 2);
            wr_data = (t == 0) ? 8'h3A : 8'h55;
        end
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (seg2 !== (7'h77 ^ POL)) begin
            errors++;
            $display("FAIL mid_pre segments got %h expected %h", seg2, 7'h77 ^ POL);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (seg2 !== POL || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL mid_async seg/busy got %h/%b expected %h/0", seg2, busy2, POL);
        end
        #1 rst = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(posedge clk);
            #1;
            checks++;
            if (seg2 !== POL || busy2 !== 1'b0) begin
                errors++;
                $display("FAIL mid_after t=%0d seg/busy got %h/%b expected %h/0", t, seg2, busy2, POL);
            end
        end
    endtask

    task automatic test_gap0;
        clear_stim();
        stim_en[0] = 1'b1;
        stim_d[0]  = 8'hF0;
        run_scenario(0, 12, "gap0_F0");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_gap0();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
